// File: rtl/ipv4_pkg.sv
// Shared IPv4 header constants and ones'-complement helpers used by the transmit
// inserter and the receive-side checker.
package ipv4_pkg;

    localparam int unsigned IPV4_HDR_BYTES = 20;
    localparam int unsigned IPV4_CKSUM_OFF = 10;
    localparam logic [7:0]  IPV4_VER_IHL   = 8'h45;

    typedef logic [15:0] cksum16_t;

    // 16-bit ones'-complement add; the end-around carry cannot ripple a second time.
    function automatic cksum16_t cksum_add(input cksum16_t a, input cksum16_t b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'd0, s[16]};
    endfunction

endpackage

// File: rtl/ip_cksum_accum.sv
// Running 16-bit ones'-complement sum of a word stream; clear wins over the stored sum but a
// word presented in the same cycle is still added onto zero.
module ip_cksum_accum
    import ipv4_pkg::*;
(
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     clear_i,
    input  logic     valid_i,
    input  cksum16_t word_i,
    output cksum16_t sum_o
);

    cksum16_t sum_q;
    cksum16_t sum_d;

    always_comb begin
        sum_d = clear_i ? '0 : sum_q;
        if (valid_i) begin
            sum_d = cksum_add(sum_d, word_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/ipv4_cksum_insert.sv
// Transmit-side IPv4 header checksum inserter: delays the beat stream by one header length and
// overwrites the checksum field with the ones'-complement sum of the header.
module ipv4_cksum_insert
    import ipv4_pkg::*;
#(
    parameter int unsigned N         = 4,
    parameter int unsigned HDR_BYTES = IPV4_HDR_BYTES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         axiiv,
    input  logic [N-1:0] axiid,
    output logic         axiov,
    output logic [N-1:0] axiod,
    output logic         hdr_err,
    output logic         runt
);

    localparam int unsigned WB  = 16 / N;
    localparam int unsigned HB  = HDR_BYTES * 8 / N;
    localparam int unsigned L   = HB;
    localparam int unsigned CK0 = IPV4_CKSUM_OFF * 8 / N;
    localparam int unsigned B0  = 8 / N;
    localparam int unsigned BW  = $clog2(HB + 1);
    localparam int unsigned WBW = $clog2(WB);

    if (!(N == 2 || N == 4 || N == 8)) begin : g_bad_n
        $error("ipv4_cksum_insert: N must be 2, 4 or 8");
    end

    // ---------------------------------------------------------------- input side
    logic          drop_q;
    logic          in_v;
    logic [BW-1:0] ibeat_q;
    logic [BW-1:0] ibeat_d;
    logic [15:0]   word_q;
    logic [15:0]   word_d;
    logic [7:0]    byte0_q;
    logic          word_v;
    logic          last_hdr;
    logic          frame_start;
    cksum16_t      sum;
    cksum16_t      ck_hold_q;
    logic          hdr_ok_q;

    // A frame cut by reset stays suppressed until the next inter-frame gap.
    assign in_v        = axiiv & ~drop_q;
    assign word_d      = {word_q[15-N:0], axiid};
    assign word_v      = in_v && (ibeat_q < BW'(HB)) && (&ibeat_q[WBW-1:0]);
    assign last_hdr    = in_v && (ibeat_q == BW'(HB - 1));
    assign frame_start = in_v && (ibeat_q == '0);

    always_comb begin
        ibeat_d = ibeat_q;
        if (!in_v) begin
            ibeat_d = '0;
        end else if (ibeat_q != BW'(HB)) begin
            ibeat_d = ibeat_q + BW'(1);
        end
    end

    ip_cksum_accum u_accum (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i (ibeat_q == '0),
        .valid_i (word_v),
        .word_i  (word_d),
        .sum_o   (sum)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q    <= 1'b1;
            ibeat_q   <= '0;
            word_q    <= '0;
            byte0_q   <= '0;
            ck_hold_q <= '0;
            hdr_ok_q  <= 1'b0;
        end else begin
            drop_q  <= drop_q & axiiv;
            ibeat_q <= ibeat_d;
            if (in_v) begin
                word_q <= word_d;
            end
            // The low byte of the shift word holds exactly the last B0 beats.
            if (in_v && (ibeat_q == BW'(B0 - 1))) begin
                byte0_q <= word_d[7:0];
            end
            // The final header word is folded in here rather than waiting a cycle for sum.
            if (last_hdr) begin
                ck_hold_q <= ~cksum_add(sum, word_d);
                hdr_ok_q  <= (byte0_q == IPV4_VER_IHL);
            end else if (frame_start) begin
                hdr_ok_q <= 1'b0;
            end
        end
    end

    // ---------------------------------------------------------------- delay line and output
    logic [L-2:0]          dl_v_q;
    logic [L-2:0][N-1:0]   dl_d_q;
    logic                  head_v;
    logic [BW-1:0]         nbeat;
    logic [BW-1:0]         obeat_q;
    logic [7:0]            ob_byte;
    logic                  ob_full;
    logic [WB-1:0][N-1:0]  ck_beats;
    logic                  frm_ok_q;
    logic                  axiov_q;
    logic [N-1:0]          axiod_q;
    logic [N-1:0]          od_d;
    logic                  hdr_err_q;
    logic                  runt_q;

    assign head_v   = dl_v_q[L-2];
    assign ob_byte  = dl_d_q[L-2 -: B0];
    assign ob_full  = &dl_v_q[L-2 -: B0];
    assign ck_beats = ck_hold_q;

    always_comb begin
        nbeat = '0;
        if (head_v && axiov_q) begin
            nbeat = (obeat_q == BW'(HB)) ? obeat_q : obeat_q + BW'(1);
        end
        od_d = dl_d_q[L-2];
        for (int j = 0; j < WB; j++) begin
            if (head_v && frm_ok_q && (nbeat == BW'(CK0 + j))) begin
                od_d = ck_beats[WB-1-j];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dl_v_q    <= '0;
            dl_d_q    <= '0;
            obeat_q   <= '0;
            frm_ok_q  <= 1'b0;
            axiov_q   <= 1'b0;
            axiod_q   <= '0;
            hdr_err_q <= 1'b0;
            runt_q    <= 1'b0;
        end else begin
            dl_v_q    <= {dl_v_q[L-3:0], in_v};
            dl_d_q    <= {dl_d_q[L-3:0], (in_v ? axiid : '0)};
            obeat_q   <= nbeat;
            axiov_q   <= head_v;
            axiod_q   <= od_d;
            hdr_err_q <= head_v && !axiov_q && (!ob_full || (ob_byte != IPV4_VER_IHL));
            runt_q    <= head_v && !dl_v_q[L-3] && (nbeat < BW'(HB - 1));
            // hdr_ok of this frame was settled by its last header beat, one cycle before output
            // beat 0; take a private copy since the next input frame may clear hdr_ok early.
            if (axiov_q && (obeat_q == '0)) begin
                frm_ok_q <= hdr_ok_q;
            end
        end
    end

    assign axiov   = axiov_q;
    assign axiod   = axiod_q;
    assign hdr_err = hdr_err_q;
    assign runt    = runt_q;

endmodule

// File: tb/tb_ipv4_cksum_insert.sv
// Randomised and directed check of ipv4_cksum_insert against a frame-level checksum model.
module tb_ipv4_cksum_insert;

    localparam int unsigned N   = 4;
    localparam int unsigned L   = 20 * 8 / N;
    localparam int unsigned BPB = 8 / N;
    localparam int unsigned CK0 = 80 / N;
    localparam int unsigned WB  = 16 / N;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic         v;
        logic [N-1:0] d;
        logic         herr;
        logic         runt;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         axiiv;
    logic [N-1:0] axiid;
    logic         axiov;
    logic [N-1:0] axiod;
    logic         hdr_err;
    logic         runt;

    exp_t         exp_q[$];
    logic [N-1:0] cap[$];
    int           n_tests = 0;
    int           n_fail = 0;
    int           herr_seen = 0;
    int           runt_seen = 0;

    always #5 clk = ~clk;

    ipv4_cksum_insert #(.N(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .axiiv   (axiiv),
        .axiid   (axiid),
        .axiov   (axiov),
        .axiod   (axiod),
        .hdr_err (hdr_err),
        .runt    (runt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Reference: header checksum over the first 20 bytes, inserted only into complete 0x45 frames.
    function automatic bq_t model_out(input bq_t fr);
        bq_t         o;
        logic [31:0] s;
        o = fr;
        if (fr.size() < 20 || fr[0] != 8'h45) return o;
        s = 0;
        for (int w = 0; w < 10; w++) s += {16'd0, fr[2*w], fr[2*w+1]};
        while (s > 32'hffff) s = (s & 32'hffff) + (s >> 16);
        s = ~s & 32'hffff;
        o[10] = s[15:8];
        o[11] = s[7:0];
        return o;
    endfunction

    function automatic logic [N-1:0] beat_of(input bq_t q, input int i);
        logic [7:0] b;
        int         k;
        b = q[i / BPB];
        k = i % BPB;
        b = b >> (8 - N * (k + 1));
        return b[N-1:0];
    endfunction

    // One clock: drive, then sample #1 after the edge against the entry queued L beats earlier.
    task automatic step(input logic v, input logic [N-1:0] d, input logic r, input exp_t e);
        exp_t x;
        rst   = r;
        axiiv = v;
        axiid = d;
        @(posedge clk);
        #1;
        if (axiov) cap.push_back(axiod);
        if (hdr_err) herr_seen++;
        if (runt) runt_seen++;
        if (r) begin
            check("rst_axiov", axiov, 0);
            check("rst_axiod", axiod, 0);
            check("rst_hdr_err", hdr_err, 0);
            check("rst_runt", runt, 0);
            exp_q.delete();
            repeat (L - 1) exp_q.push_back('0);
        end else begin
            exp_q.push_back(e);
            if (exp_q.size() == L) begin
                x = exp_q.pop_front();
                check("axiov", axiov, x.v);
                if (x.v) check("axiod", axiod, x.d);
                check("hdr_err", hdr_err, x.herr);
                check("runt", runt, x.runt);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, '0, 1'b0, '0);
    endtask

    task automatic send_frame(input bq_t fr, input int gap, input int rst_at);
        bq_t  o;
        exp_t e;
        int   nb;
        bit   dropped;
        o       = model_out(fr);
        nb      = fr.size() * BPB;
        dropped = 0;
        for (int i = 0; i < nb; i++) begin
            e.v    = !dropped;
            e.d    = dropped ? '0 : beat_of(o, i);
            e.herr = !dropped && (i == 0) && (fr[0] != 8'h45);
            e.runt = !dropped && (i == nb - 1) && (fr.size() < 20);
            if (i == rst_at) dropped = 1;
            step(1'b1, beat_of(fr, i), (i == rst_at), e);
        end
        idle(gap);
    endtask

    task automatic check_ck(input string tag, input int base, input logic [15:0] want);
        logic [15:0]  got;
        logic [N-1:0] nib;
        got = '0;
        for (int j = 0; j < WB; j++) begin
            if (base + CK0 + j < cap.size()) nib = cap[base + CK0 + j];
            else nib = 'x;
            got = (got << N) | 16'(nib);
        end
        check(tag, got, want);
    endtask

    initial begin
        bq_t a;
        bq_t b;
        bq_t fr;
        int  cnt0;
        int  len;

        a = '{8'h45, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
              8'h00, 8'h00, 8'hc0, 8'ha8, 8'h00, 8'h01, 8'hc0, 8'ha8, 8'h00, 8'hc7,
              8'hde, 8'had, 8'hbe, 8'hef};

        rst   = 1'b1;
        axiiv = 1'b0;
        axiid = '0;
        repeat (3) step(1'b0, '0, 1'b1, '0);
        idle(3);

        // Back-to-back copies of the reference header, one-cycle gap.
        cap.delete();
        send_frame(a, 1, -1);
        send_frame(a, L + 2, -1);
        check("b2b_len", cap.size(), 96);
        check_ck("ck_first", 0, 16'hb861);
        check_ck("ck_second", 48, 16'hb861);

        // Wrong version/IHL byte passes through untouched.
        b    = a;
        b[0] = 8'h46;
        cnt0 = herr_seen;
        cap.delete();
        send_frame(b, L + 2, -1);
        check("hdr_err_pulses", herr_seen - cnt0, 1);
        check_ck("ck_bad_passthru", 0, 16'h0000);

        // Good frame then a 12-byte runt: previous checksum must not leak.
        fr.delete();
        for (int i = 0; i < 12; i++) fr.push_back(a[i]);
        cnt0 = runt_seen;
        cap.delete();
        send_frame(a, 1, -1);
        send_frame(fr, L + 2, -1);
        check("runt_len", cap.size(), 72);
        check("runt_pulses", runt_seen - cnt0, 1);
        check_ck("ck_before_runt", 0, 16'hb861);
        check_ck("ck_runt", 48, 16'h0000);

        // Reset at input beat 25 drops the frame; the next one is intact.
        cap.delete();
        send_frame(a, L + 2, 25);
        check("rst_drop_len", cap.size(), 0);
        send_frame(a, L + 2, -1);
        check("post_rst_len", cap.size(), 48);
        check_ck("ck_post_rst", 0, 16'hb861);

        // Random frames: runts, bad version bytes, nonzero checksum fields, short gaps.
        for (int f = 0; f < 60; f++) begin
            fr.delete();
            len = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 19) : $urandom_range(20, 36);
            for (int i = 0; i < len; i++) fr.push_back(8'($urandom));
            fr[0] = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h45;
            if (len > 11 && $urandom_range(0, 3) != 0) begin
                fr[10] = 8'h00;
                fr[11] = 8'h00;
            end
            send_frame(fr, $urandom_range(1, 4), -1);
        end
        idle(L + 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
